// File: rtl/hold_run_sched.sv
// Round-robin scheduler sharing one IDLE/RUN/LAST run engine among N_REQ requesters.
// Latches the winner and its run length, gates for that many cycles, then closes with a done/abort pulse.
module hold_run_sched #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 4,
  parameter int ID_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*CNT_W-1:0]   len_i,
  output logic [N_REQ-1:0]         gnt,
  output logic [ID_W-1:0]          gnt_id,
  output logic                     g,
  output logic                     f,
  output logic                     busy,
  output logic                     done,
  output logic                     abort
);

  generate
    if (N_REQ < 2 || N_REQ > 16 || (1 << ID_W) < N_REQ) begin : g_bad_params
      $error("hold_run_sched: N_REQ must be 2..16 and fit in ID_W bits");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [CNT_W-1:0]  len_q, len_nxt;
  logic [ID_W-1:0]   ptr, ptr_nxt;
  logic [ID_W-1:0]   id_nxt;
  logic [N_REQ-1:0]  gnt_nxt;
  logic              g_nxt, f_nxt, busy_nxt, done_nxt, abort_nxt;

  // Arbitration: lowest requester at or above ptr wins, else lowest overall (wrap).
  logic [N_REQ-1:0]  req_hi;
  logic [ID_W-1:0]   win_hi, win_lo, win;
  logic [CNT_W-1:0]  win_len;
  logic              req_cur;
  logic [ID_W-1:0]   ptr_inc;

  // NOTE: every combinational output gets a default before any branch, so no latch can be inferred.
  always_comb begin
    req_hi = '0;
    win_hi = '0;
    win_lo = '0;
    for (int k = 0; k < N_REQ; k++) begin
      req_hi[k] = req[k] && (k >= int'(ptr));
    end
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_hi[k]) win_hi = ID_W'(k);
      if (req[k])    win_lo = ID_W'(k);
    end
    win = (|req_hi) ? win_hi : win_lo;
  end

  always_comb begin
    win_len = '0;
    req_cur = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (ID_W'(k) == win)    win_len = len_i[k*CNT_W +: CNT_W];
      if (ID_W'(k) == gnt_id) req_cur = req[k];
    end
  end

  assign ptr_inc = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    len_nxt   = len_q;
    ptr_nxt   = ptr;
    id_nxt    = gnt_id;
    gnt_nxt   = '0;
    g_nxt     = 1'b0;
    f_nxt     = f;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    abort_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = RUN;
          gnt_nxt   = N_REQ'(1) << win;
          id_nxt    = win;
          g_nxt     = 1'b1;
          busy_nxt  = 1'b1;
          cnt_nxt   = '0;
          // A programmed length of zero still runs for one cycle.
          len_nxt   = (win_len == '0) ? CNT_W'(1) : win_len;
        end
      end

      RUN: begin
        // A dropped request ends the run here; abort wins over a coincident normal exit.
        if (!req_cur || cnt == len_q - CNT_W'(1)) begin
          state_nxt = LAST;
          busy_nxt  = 1'b1;
          done_nxt  = 1'b1;
          abort_nxt = !req_cur;
          f_nxt     = ~f;
          ptr_nxt   = ptr_inc;
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
          gnt_nxt   = gnt;
          g_nxt     = 1'b1;
          busy_nxt  = 1'b1;
        end
      end

      LAST: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      len_q  <= '0;
      ptr    <= '0;
      gnt    <= '0;
      gnt_id <= '0;
      g      <= 1'b0;
      f      <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      abort  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      len_q  <= len_nxt;
      ptr    <= ptr_nxt;
      gnt    <= gnt_nxt;
      gnt_id <= id_nxt;
      g      <= g_nxt;
      f      <= f_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      abort  <= abort_nxt;
    end
  end

endmodule

// File: tb/tb_hold_run_sched.sv
// Directed bench for hold_run_sched: inputs driven and outputs sampled on the falling edge.
module tb_hold_run_sched;
  localparam int N_REQ = 4;
  localparam int CNT_W = 4;
  localparam int ID_W  = 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*CNT_W-1:0] len_i;
  logic [N_REQ-1:0]       gnt;
  logic [ID_W-1:0]        gnt_id;
  logic                   g, f, busy, done, abort;

  int checks   = 0;
  int failures = 0;

  hold_run_sched #(.N_REQ(N_REQ), .CNT_W(CNT_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .len_i(len_i), .gnt(gnt), .gnt_id(gnt_id),
    .g(g), .f(f), .busy(busy), .done(done), .abort(abort)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic set_len(input int k, input int v);
    len_i[k*CNT_W +: CNT_W] = CNT_W'(v);
  endtask

  // Waits (bounded) for g, counts g-high cycles and returns at the LAST cycle.
  // At RUN cycle chg_at the inputs are replaced by chg_req/chg_len.
  task automatic measure_run(input int chg_at, input logic [N_REQ-1:0] chg_req,
                             input logic [N_REQ*CNT_W-1:0] chg_len,
                             output int glen, output logic [ID_W-1:0] id,
                             output logic [N_REQ-1:0] gv);
    int k;
    glen = 0; id = '0; gv = '0; k = 0;
    while (!g && k < 40) begin @(negedge clk); k++; end
    if (!g) return;
    id = gnt_id; gv = gnt;
    while (g && glen < 40) begin
      glen++;
      if (glen == chg_at) begin req = chg_req; len_i = chg_len; end
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #2 rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; len_i = '0;
    #12;
    checks++;
    if ({gnt, gnt_id, g, f, busy, done, abort} !== '0) begin
      failures++; $display("FAIL reset_outputs got=%b exp=0", {gnt, gnt_id, g, f, busy, done, abort});
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int glen; logic [ID_W-1:0] id; logic [N_REQ-1:0] gv;
    set_len(0, 5); req = 4'b0001;
    @(negedge clk);
    checks++;
    if (g !== 1'b1 || gnt !== 4'b0001) begin
      failures++; $display("FAIL basic_first_grant got g=%b gnt=%b exp g=1 gnt=0001", g, gnt);
    end
    measure_run(0, '0, '0, glen, id, gv);
    checks++;
    if (glen !== 5 || id !== 2'd0 || gv !== 4'b0001) begin
      failures++; $display("FAIL basic_run got len=%0d id=%0d gnt=%b exp len=5 id=0 gnt=0001", glen, id, gv);
    end
    checks++;
    if ({done, abort, f, busy, g, gnt, gnt_id} !== {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd0}) begin
      failures++; $display("FAIL basic_last got done=%b abort=%b f=%b busy=%b g=%b gnt=%b id=%0d exp 1 0 1 1 0 0000 0",
                           done, abort, f, busy, g, gnt, gnt_id);
    end
    @(negedge clk);
    checks++;
    if ({g, done, busy} !== 3'b000) begin
      failures++; $display("FAIL basic_idle_gap got g=%b done=%b busy=%b exp 000", g, done, busy);
    end
    @(negedge clk);
    checks++;
    if (g !== 1'b1) begin
      failures++; $display("FAIL basic_second_start got g=%b exp 1", g);
    end
    measure_run(0, '0, '0, glen, id, gv);
    req = '0;
    checks++;
    if (glen !== 5 || done !== 1'b1 || f !== 1'b0) begin
      failures++; $display("FAIL basic_second_run got len=%0d done=%b f=%b exp len=5 done=1 f=0", glen, done, f);
    end
    @(negedge clk);
  endtask

  task automatic test_len_edges();
    int glen; logic [ID_W-1:0] id; logic [N_REQ-1:0] gv;
    set_len(2, 0); req = 4'b0100;
    measure_run(0, '0, '0, glen, id, gv);
    req = '0;
    checks++;
    if (glen !== 1 || id !== 2'd2 || done !== 1'b1) begin
      failures++; $display("FAIL len_zero got len=%0d id=%0d done=%b exp len=1 id=2 done=1", glen, id, done);
    end
    @(negedge clk);
    set_len(2, 15); req = 4'b0100;
    measure_run(0, '0, '0, glen, id, gv);
    req = '0;
    checks++;
    if (glen !== 15 || id !== 2'd2 || done !== 1'b1) begin
      failures++; $display("FAIL len_max got len=%0d id=%0d done=%b exp len=15 id=2 done=1", glen, id, done);
    end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int glen; int toggles; logic [ID_W-1:0] id; logic [N_REQ-1:0] gv;
    logic fprev;
    logic [ID_W-1:0] exp_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    toggles = 0;
    len_i = 16'h2222; req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      fprev = f;
      measure_run(0, '0, '0, glen, id, gv);
      if (f !== fprev) toggles++;
      checks++;
      if (id !== exp_id[r] || glen !== 2 || gv !== (4'b0001 << exp_id[r])) begin
        failures++; $display("FAIL rr_run%0d got id=%0d len=%0d gnt=%b exp id=%0d len=2", r, id, glen, gv, exp_id[r]);
      end
    end
    req = '0;
    checks++;
    if (toggles !== 5 || f !== 1'b1) begin
      failures++; $display("FAIL rr_f_toggles got toggles=%0d f=%b exp toggles=5 f=1", toggles, f);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    int glen; logic [ID_W-1:0] id; logic [N_REQ-1:0] gv;
    logic fprev;
    len_i = 16'h2282; req = 4'b0010; fprev = f;
    measure_run(3, 4'b0000, len_i, glen, id, gv);
    checks++;
    if (glen !== 3 || id !== 2'd1) begin
      failures++; $display("FAIL abort_len got len=%0d id=%0d exp len=3 id=1", glen, id);
    end
    checks++;
    if ({done, abort, busy, g, gnt} !== {1'b1, 1'b1, 1'b1, 1'b0, 4'b0000} || f !== ~fprev) begin
      failures++; $display("FAIL abort_last got done=%b abort=%b busy=%b g=%b gnt=%b f=%b exp 1 1 1 0 0000 f=%b",
                           done, abort, busy, g, gnt, f, ~fprev);
    end
    req = 4'b1111;
    measure_run(0, '0, '0, glen, id, gv);
    req = '0;
    checks++;
    if (id !== 2'd2 || glen !== 2 || abort !== 1'b0) begin
      failures++; $display("FAIL abort_next_grant got id=%0d len=%0d abort=%b exp id=2 len=2 abort=0", id, glen, abort);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int k; int glen; logic saw_done; logic [ID_W-1:0] id; logic [N_REQ-1:0] gv;
    set_len(2, 10); req = 4'b0100;
    k = 0;
    while (!g && k < 40) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    checks++;
    if (g !== 1'b1 || gnt_id !== 2'd2) begin
      failures++; $display("FAIL rstmid_running got g=%b id=%0d exp g=1 id=2", g, gnt_id);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, gnt_id, g, f, busy, done, abort} !== '0) begin
      failures++; $display("FAIL rstmid_async got=%b exp=0", {gnt, gnt_id, g, f, busy, done, abort});
    end
    req = '0; saw_done = 1'b0;
    repeat (3) begin @(negedge clk); if (done) saw_done = 1'b1; end
    rst_n = 1'b1; req = 4'b1010;
    @(negedge clk); if (done) saw_done = 1'b1;
    checks++;
    if (saw_done !== 1'b0) begin
      failures++; $display("FAIL rstmid_no_done got saw_done=%b exp 0", saw_done);
    end
    measure_run(0, '0, '0, glen, id, gv);
    req = 4'b1000;
    checks++;
    if (id !== 2'd1) begin
      failures++; $display("FAIL rstmid_ptr_zero got id=%0d exp 1", id);
    end
    measure_run(0, '0, '0, glen, id, gv);
    req = '0;
    checks++;
    if (id !== 2'd3 || gv !== 4'b1000) begin
      failures++; $display("FAIL rstmid_grant3 got id=%0d gnt=%b exp id=3 gnt=1000", id, gv);
    end
    @(negedge clk);
  endtask

  task automatic test_len_change();
    int glen; logic [ID_W-1:0] id; logic [N_REQ-1:0] gv;
    logic [N_REQ*CNT_W-1:0] new_len;
    set_len(0, 6); req = 4'b0001;
    new_len = len_i; new_len[CNT_W-1:0] = 4'd2;
    measure_run(2, 4'b0001, new_len, glen, id, gv);
    checks++;
    if (glen !== 6 || id !== 2'd0) begin
      failures++; $display("FAIL lenchg_first got len=%0d id=%0d exp len=6 id=0", glen, id);
    end
    measure_run(0, '0, '0, glen, id, gv);
    req = '0;
    checks++;
    if (glen !== 2 || id !== 2'd0) begin
      failures++; $display("FAIL lenchg_second got len=%0d id=%0d exp len=2 id=0", glen, id);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len_edges();
    test_round_robin();
    test_abort();
    test_reset_mid_run();
    test_len_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
